// File: rtl/hazard_stall_controller_if.sv
// Hazard-detection inputs and pipeline-control outputs of the stall/flush sequencer.
// The master side is the controller and the slave side is the pipeline.
interface hazard_stall_controller_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       if_id_rs1;
    logic [4:0]       if_id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rd;
    logic             ex_branch_taken;
    logic             mem_busy;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_flush;
    logic             ex_mem_write;
    logic             mem_wb_write;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout_err;

    modport master (
        input  if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2,
               id_ex_mem_read, id_ex_rd, ex_branch_taken, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mem_wb_write, stall_cnt, flush_cnt, mem_timeout_err
    );

    modport slave (
        output if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2,
               id_ex_mem_read, id_ex_rd, ex_branch_taken, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mem_wb_write, stall_cnt, flush_cnt, mem_timeout_err
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch redirect,
// data-memory wait freeze with timeout, plus saturating stall/flush counters.
module hazard_stall_controller #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hazard_stall_controller_if.master bus
);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WAIT_W:0]   wait_inc;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              err_q, err_d;
    logic              load_use;
    logic              stall_inc, flush_inc;

    always_comb begin
        load_use = bus.id_ex_mem_read && (bus.id_ex_rd != 5'd0) &&
                   ((bus.id_uses_rs1 && (bus.id_ex_rd == bus.if_id_rs1)) ||
                    (bus.id_uses_rs2 && (bus.id_ex_rd == bus.if_id_rs2)));
    end

    assign wait_inc = {1'b0, wait_q} + 1'b1;

    always_comb begin
        state_d          = state_q;
        wait_d           = wait_q;
        err_d            = err_q;
        stall_inc        = 1'b0;
        flush_inc        = 1'b0;
        bus.pc_write     = 1'b1;
        bus.if_id_write  = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_write  = 1'b1;
        bus.id_ex_flush  = 1'b0;
        bus.ex_mem_write = 1'b1;
        bus.mem_wb_write = 1'b1;

        if (state_q == ERROR) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_write  = 1'b0;
            bus.ex_mem_write = 1'b0;
            bus.mem_wb_write = 1'b0;
        end else if (bus.mem_busy) begin
            // wait_q is zero in RUN, so the entry cycle counts as the first wait cycle
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_write  = 1'b0;
            bus.ex_mem_write = 1'b0;
            bus.mem_wb_write = 1'b0;
            stall_inc        = 1'b1;
            state_d          = MEM_WAIT;
            wait_d           = wait_inc[WAIT_W-1:0];
            if (wait_inc >= (WAIT_W + 1)'(MEM_TIMEOUT)) begin
                state_d = ERROR;
                err_d   = 1'b1;
            end
        end else begin
            state_d = RUN;
            wait_d  = '0;
            if (bus.ex_branch_taken) begin
                bus.if_id_flush = 1'b1;
                bus.id_ex_flush = 1'b1;
                flush_inc       = 1'b1;
            end else if (load_use) begin
                bus.pc_write    = 1'b0;
                bus.if_id_write = 1'b0;
                bus.id_ex_flush = 1'b1;
                stall_inc       = 1'b1;
            end
        end

        // Reset overrides everything so the pipeline fills with NOPs/bubbles at once
        if (!rst_n) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.if_id_flush  = 1'b1;
            bus.id_ex_write  = 1'b0;
            bus.id_ex_flush  = 1'b1;
            bus.ex_mem_write = 1'b0;
            bus.mem_wb_write = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt       = stall_cnt_q;
    assign bus.flush_cnt       = flush_cnt_q;
    assign bus.mem_timeout_err = err_q;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with MEM_TIMEOUT=4 and CNT_W=4.
module tb_hazard_stall_controller;
    // Control vector order: pc_write, if_id_write, if_id_flush, id_ex_write,
    // id_ex_flush, ex_mem_write, mem_wb_write
    localparam logic [6:0] V_RUN    = 7'b1101011;
    localparam logic [6:0] V_FREEZE = 7'b0000000;
    localparam logic [6:0] V_BR     = 7'b1111111;
    localparam logic [6:0] V_LU     = 7'b0001111;
    localparam logic [6:0] V_RST    = 7'b0010100;

    logic clk;
    logic rst_n;
    int unsigned checks;
    int unsigned errors;

    hazard_stall_controller_if #(.CNT_W(4)) bus ();

    hazard_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ctl();
        return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
                bus.id_ex_flush, bus.ex_mem_write, bus.mem_wb_write};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic busy, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2);
        bus.ex_branch_taken = br;
        bus.mem_busy        = busy;
        bus.id_ex_mem_read  = mr;
        bus.id_ex_rd        = rd;
        bus.if_id_rs1       = rs1;
        bus.if_id_rs2       = rs2;
        bus.id_uses_rs1     = u1;
        bus.id_uses_rs2     = u2;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        #1;
        chk("rst_ctl", 32'(ctl()), 32'(V_RST));
        chk("rst_stall", 32'(bus.stall_cnt), 0);
        chk("rst_flush", 32'(bus.flush_cnt), 0);
        chk("rst_err", 32'(bus.mem_timeout_err), 0);
        tick();
        rst_n = 1'b1;
        idle();
        chk("idle_ctl", 32'(ctl()), 32'(V_RUN));

        // Load-use on rs1: one bubble, then the bubble reaches EX
        tick();
        drive(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        chk("lu_ctl", 32'(ctl()), 32'(V_LU));
        chk("lu_stall_pre", 32'(bus.stall_cnt), 0);
        tick();
        idle();
        chk("lu_after_ctl", 32'(ctl()), 32'(V_RUN));
        chk("lu_stall", 32'(bus.stall_cnt), 1);

        // x0 destination and unused operand never stall
        drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        chk("x0_ctl", 32'(ctl()), 32'(V_RUN));
        drive(1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
        chk("unused_rs2_ctl", 32'(ctl()), 32'(V_RUN));
        drive(1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1);
        chk("lu_rs2_ctl", 32'(ctl()), 32'(V_LU));
        drive(1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1);
        chk("no_load_ctl", 32'(ctl()), 32'(V_RUN));
        tick();
        chk("x0_stall", 32'(bus.stall_cnt), 1);

        // Branch over load-use
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        chk("br_lu_ctl", 32'(ctl()), 32'(V_BR));
        tick();
        idle();
        chk("br_flush", 32'(bus.flush_cnt), 1);
        chk("br_stall", 32'(bus.stall_cnt), 0);

        // Memory wait with a pending branch
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("mw_freeze", 32'(ctl()), 32'(V_FREEZE));
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("mw_br_ctl", 32'(ctl()), 32'(V_BR));
        chk("mw_stall", 32'(bus.stall_cnt), 3);
        chk("mw_flush_pre", 32'(bus.flush_cnt), 0);
        tick();
        idle();
        chk("mw_flush", 32'(bus.flush_cnt), 1);
        chk("mw_run_ctl", 32'(ctl()), 32'(V_RUN));

        // Wait counter clears when mem_busy drops before the limit
        do_reset();
        for (int r = 0; r < 2; r++) begin
            drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) tick();
            idle();
            chk("to_partial_ctl", 32'(ctl()), 32'(V_RUN));
            chk("to_partial_err", 32'(bus.mem_timeout_err), 0);
            tick();
        end
        chk("to_partial_stall", 32'(bus.stall_cnt), 6);

        // Timeout after MEM_TIMEOUT consecutive busy cycles
        drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        chk("to_err_before", 32'(bus.mem_timeout_err), 0);
        tick();
        chk("to_err", 32'(bus.mem_timeout_err), 1);
        drive(1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        chk("to_err_ctl", 32'(ctl()), 32'(V_FREEZE));
        tick();
        chk("to_err_hold_ctl", 32'(ctl()), 32'(V_FREEZE));
        chk("to_err_hold", 32'(bus.mem_timeout_err), 1);
        chk("to_stall", 32'(bus.stall_cnt), 10);
        chk("to_flush", 32'(bus.flush_cnt), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("to_rst_ctl", 32'(ctl()), 32'(V_RST));
        chk("to_rst_err", 32'(bus.mem_timeout_err), 0);
        chk("to_rst_stall", 32'(bus.stall_cnt), 0);
        tick();
        rst_n = 1'b1;
        idle();
        chk("to_run_ctl", 32'(ctl()), 32'(V_RUN));

        // Saturation of both counters
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        chk("sat_stall_15", 32'(bus.stall_cnt), 15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_stall_hold", 32'(bus.stall_cnt), 15);
        chk("sat_lu_ctl", 32'(ctl()), 32'(V_LU));
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) tick();
        chk("sat_flush", 32'(bus.flush_cnt), 15);
        chk("sat_stall_keep", 32'(bus.stall_cnt), 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
